adder_result_fifo: RTL and testbench
====================================

Name: adder_result_fifo

Overview:
- Result buffer directly downstream of the 4-stage pipelined 32-bit adder.
- Accepts {sum, carry} on the adder's valid/allow handshake and drives the adder's out_allow input.
- Stamps each result with a sequence number and presents results in order to the consumer over a valid/ready interface.
- Decouples consumer stalls from the adder so the adder keeps streaming until this buffer is full.

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
SEQ_W, 8, width of the sequence tag; wraps modulo 2^SEQ_W
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flush  input  1  synchronous clear of all buffered entries
in_valid  input  1  connects to the adder's validout
in_sum  input  32  connects to the adder's sum_out
in_cout  input  1  connects to the adder's c_out
in_allow  output  1  connects to the adder's out_allow
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts the head entry
out_sum  output  32  head sum
out_cout  output  1  head carry
out_seq  output  SEQ_W  head sequence tag
count  output  CNT_W  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- All state updates on posedge clk. rst has priority over everything.
- Reset values: count=0, rd/wr pointers=0, seq counter=0, out_valid=0, empty=1, full=0. out_sum, out_cout and out_seq read the entry at pointer 0; their value is don't-care while out_valid=0.
- push = in_valid && in_allow. pop = out_valid && out_ready.
- in_allow = !flush && (!full || out_ready).
  - This is a combinational path from out_ready to in_allow, so a full FIFO accepts a push in the same cycle it pops.
  - in_allow must not depend on in_valid. The adder already makes out_allow feed its allowin, so any dependence on in_valid would close a combinational loop.
- out_valid = !empty.
- out_* are driven from the storage entry at the read pointer. There is no input-to-output bypass.
  - Minimum latency is 1 cycle: a push at edge N gives out_valid=1 after edge N.
  - Results pass through FIFO storage only; nothing is captured from the adder side except on a push.
- On push: write {in_sum, in_cout, seq} at the write pointer, advance the write pointer modulo DEPTH, and increment seq modulo 2^SEQ_W.
- On pop: advance the read pointer modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
- Full with out_ready=1 and in_valid=1: push and pop in the same cycle, count stays at DEPTH, order is preserved.
- Empty with out_ready=1: no pop, no underflow, count stays 0.
- flush=1 (when not in reset):
  - count and pointers go to 0 and all entries are discarded.
  - in_allow is 0 during that cycle, so the adder holds its result.
  - Any pop handshake in that cycle is ignored.
  - seq is NOT cleared, so tags keep increasing across a flush.
- Reset mid-stream: entries are lost, seq returns to 0, in_allow is 1 in the cycle after rst deasserts.
- The upstream adder must see in_allow=1 whenever count<DEPTH. The FIFO never drops a presented in_valid beat.

Optional Feature:
- Macro: ADDER_RESULT_STATS_EN.
- Defined: adds outputs stat_total[31:0] and stat_carry[31:0].
  - stat_total increments on every push.
  - stat_carry increments on every push with in_cout=1.
  - Both saturate at 32'hFFFF_FFFF, clear on rst, and are unaffected by flush.
- Not defined: the ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset, then push 3 results (sum=32'h1, 32'h2, 32'hFFFF_FFFF with cout=1) with out_ready=0 -> count=3, out_seq=0, out_sum=32'h1; then hold out_ready=1 -> outputs in order with seq 0,1,2, cout=0,0,1, then empty=1.
- Push 4 with out_ready=0 -> full=1 and in_allow=0. A 5th in_valid beat is held: in_allow stays 0 and count stays 4. Then out_ready=1 -> in_allow=1 in the same cycle, push and pop together, count stays 4, 5th result reaches the output with seq=4.
- Continuous in_valid and out_ready for 300 beats -> count≤1 throughout, out_seq wraps 255→0, no beat lost or duplicated.
- Load 2 entries, assert flush together with out_valid=1, out_ready=1 and in_valid=1 -> count=0, in_allow=0 during flush, no pop counted; the next push gets seq=2.
- Assert rst with 3 entries buffered -> next cycle count=0, empty=1, in_allow=1; the next push gets seq=0.
- With ADDER_RESULT_STATS_EN defined: 10 pushes, 4 with cout=1, plus a flush -> stat_total=10 and stat_carry=4, both unchanged by the flush.

Source files
------------

// File: rtl/adder_result_fifo.sv
// Result buffer behind the 4-stage pipelined adder: tags each {sum, carry} with a sequence number
// and replays results in order over valid/ready. Optional push statistics under ADDER_RESULT_STATS_EN.
module adder_result_fifo #(
    parameter int DEPTH = 4,
    parameter int SEQ_W = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_sum,
    input  logic             in_cout,
    output logic             in_allow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic [SEQ_W-1:0] out_seq,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
`ifdef ADDER_RESULT_STATS_EN
    ,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_carry
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]      sum;
        logic             cout;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SEQ_W-1:0] seq;
    logic             push;
    logic             pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    // Must never look at in_valid: the adder feeds out_allow back into its own allowin.
    assign in_allow = !flush && (!full || out_ready);

    assign push = in_valid && in_allow;
    assign pop  = out_valid && out_ready && !flush;

    assign out_sum  = mem[rd_ptr].sum;
    assign out_cout = mem[rd_ptr].cout;
    assign out_seq  = mem[rd_ptr].seq;

    // NOTE: storage has no reset; out_* are don't-care while out_valid=0, and resetting
    // the array would only add a wide reset fan-out to plain data registers.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= '{sum: in_sum, cout: in_cout, seq: seq};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq    <= '0;
        end else if (flush) begin
            // Tags deliberately keep counting across a flush.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                seq    <= seq + SEQ_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef ADDER_RESULT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_total <= '0;
            stat_carry <= '0;
        end else if (push) begin
            if (stat_total != 32'hFFFF_FFFF) begin
                stat_total <= stat_total + 32'd1;
            end
            if (in_cout && stat_carry != 32'hFFFF_FFFF) begin
                stat_carry <= stat_carry + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Self-checking bench for adder_result_fifo: table-driven vectors plus a scoreboard queue,
// with hand-written flush/reset/wrap sequences; stats checks compile under ADDER_RESULT_STATS_EN.
module tb_adder_result_fifo;

    localparam int DEPTH = 4;
    localparam int SEQ_W = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_sum;
    logic             in_cout;
    logic             in_allow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             out_cout;
    logic [SEQ_W-1:0] out_seq;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef ADDER_RESULT_STATS_EN
    logic [31:0]      stat_total;
    logic [31:0]      stat_carry;
`endif

    adder_result_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_sum(in_sum), .in_cout(in_cout), .in_allow(in_allow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_seq(out_seq),
        .count(count), .full(full), .empty(empty)
`ifdef ADDER_RESULT_STATS_EN
        , .stat_total(stat_total), .stat_carry(stat_carry)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      sum;
        logic             cout;
        logic [SEQ_W-1:0] seq;
    } res_t;

    typedef struct {
        logic        rs;
        logic        v;
        logic [31:0] sum;
        logic        cout;
        logic        rdy;
        logic        fl;
        int          exp_count;
        logic        exp_allow;
    } vec_t;

    res_t             sb[$];
    logic [SEQ_W-1:0] m_seq;
    logic             m_push;
    logic             m_pop;
    logic             m_flush;
    logic [31:0]      m_sum;
    logic             m_cout;
    int               tests = 0;
    int               fails = 0;
    logic [SEQ_W-1:0] last_seq;
    logic             have_last;
    logic             wrap_seen;
    int               max_count;
    vec_t             vecs[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_sum = 32'hDEAD_BEEF; in_cout = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_seq = '0;
        have_last = 1'b0;
    endtask

    // Drive one cycle's inputs, let them settle, and compare against the model before the edge.
    task automatic apply(input logic v, input logic [31:0] s, input logic c, input logic rdy, input logic fl);
        logic exp_allow;
        res_t head;
        in_valid = v; in_sum = s; in_cout = c; out_ready = rdy; flush = fl;
        #1;
        exp_allow = !fl && (sb.size() < DEPTH || rdy);
        check("in_allow", in_allow, exp_allow);
        check("count", count, sb.size());
        check("empty", empty, sb.size() == 0);
        check("full", full, sb.size() == DEPTH);
        check("out_valid", out_valid, sb.size() != 0);
        if (int'(count) > max_count) max_count = int'(count);
        if (sb.size() != 0) begin
            head = sb[0];
            check("out_sum", out_sum, head.sum);
            check("out_cout", out_cout, head.cout);
            check("out_seq", out_seq, head.seq);
        end
        m_pop   = (sb.size() != 0) && rdy && !fl;
        m_push  = v && exp_allow;
        m_flush = fl;
        m_sum   = s;
        m_cout  = c;
        if (m_pop) begin
            if (have_last && last_seq == 8'hFF && out_seq == 8'h00) wrap_seen = 1'b1;
            last_seq  = out_seq;
            have_last = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        if (m_flush) begin
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) sb.push_back('{sum: m_sum, cout: m_cout, seq: m_seq});
        end
        if (m_push) m_seq = m_seq + 1'b1;
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] s, input logic c, input logic rdy,
                                input int ec, input logic ea);
        vec_t r;
        r = '{rs: 1'b0, v: v, sum: s, cout: c, rdy: rdy, fl: 1'b0, exp_count: ec, exp_allow: ea};
        return r;
    endfunction

    initial begin
        wrap_seen = 1'b0;
        max_count = 0;

        // Three results held, then drained in order.
        vecs[0]  = mk(1, 32'h1,         0, 0, 0, 1);
        vecs[1]  = mk(1, 32'h2,         0, 0, 1, 1);
        vecs[2]  = mk(1, 32'hFFFF_FFFF, 1, 0, 2, 1);
        vecs[3]  = mk(0, 32'h0,         0, 0, 3, 1);
        vecs[4]  = mk(0, 32'h0,         0, 1, 3, 1);
        vecs[5]  = mk(0, 32'h0,         0, 1, 2, 1);
        vecs[6]  = mk(0, 32'h0,         0, 1, 1, 1);
        vecs[7]  = mk(0, 32'h0,         0, 1, 0, 1);
        vecs[8]  = mk(0, 32'h0,         0, 0, 0, 1);
        vecs[8].rs = 1'b1;
        // Fill to full, hold a 5th beat, then push and pop together.
        vecs[9]  = mk(1, 32'h10,        0, 0, 0, 1);
        vecs[10] = mk(1, 32'h11,        1, 0, 1, 1);
        vecs[11] = mk(1, 32'h12,        0, 0, 2, 1);
        vecs[12] = mk(1, 32'h13,        1, 0, 3, 1);
        vecs[13] = mk(1, 32'h14,        0, 0, 4, 0);
        vecs[14] = mk(1, 32'h14,        0, 0, 4, 0);
        vecs[15] = mk(1, 32'h14,        0, 1, 4, 1);
        vecs[16] = mk(0, 32'h0,         0, 1, 4, 1);
        vecs[17] = mk(0, 32'h0,         0, 1, 3, 1);
        vecs[18] = mk(0, 32'h0,         0, 1, 2, 1);
        vecs[19] = mk(0, 32'h0,         0, 1, 1, 1);
        vecs[20] = mk(0, 32'h0,         0, 1, 0, 1);

        do_reset();
        #1;
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_full", full, 0);
        check("reset_out_valid", out_valid, 0);

        for (int i = 0; i < 21; i++) begin
            if (vecs[i].rs) begin
                do_reset();
            end else begin
                apply(vecs[i].v, vecs[i].sum, vecs[i].cout, vecs[i].rdy, vecs[i].fl);
                check("tbl_count", count, vecs[i].exp_count);
                check("tbl_allow", in_allow, vecs[i].exp_allow);
                if (i == 19) check("tbl_fifth_seq", out_seq, 4);
                tick();
            end
        end

        // Streaming: one beat in and one out per cycle, tag wraps past 255.
        do_reset();
        max_count = 0;
        wrap_seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            tick();
        end
        check("stream_max_count_le1", max_count <= 1, 1);
        check("stream_seq_wrapped", wrap_seen, 1);

        // Flush with a pop and a push both presented in the same cycle.
        do_reset();
        apply(1, 32'hA0, 0, 0, 0); tick();
        apply(1, 32'hA1, 1, 0, 0); tick();
        apply(1, 32'hA2, 0, 1, 1);
        check("flush_allow", in_allow, 0);
        check("flush_out_valid", out_valid, 1);
        tick();
        apply(1, 32'hA3, 1, 0, 0);
        check("post_flush_count", count, 0);
        tick();
        apply(0, 32'h0, 0, 1, 0);
        check("post_flush_seq", out_seq, 2);
        check("post_flush_sum", out_sum, 32'hA3);
        tick();

        // Reset with entries buffered.
        apply(1, 32'hB0, 0, 0, 0); tick();
        apply(1, 32'hB1, 0, 0, 0); tick();
        apply(1, 32'hB2, 0, 0, 0); tick();
        check("pre_reset_count", count, 3);
        do_reset();
        apply(1, 32'hC0, 1, 0, 0);
        check("post_reset_allow", in_allow, 1);
        check("post_reset_empty", empty, 1);
        tick();
        apply(0, 32'h0, 0, 1, 0);
        check("post_reset_seq", out_seq, 0);
        check("post_reset_cout", out_cout, 1);
        tick();

`ifdef ADDER_RESULT_STATS_EN
        do_reset();
        #1;
        check("stats_reset_total", stat_total, 0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 32'(i), (i % 3) == 0, 1'b1, 1'b0);
            tick();
        end
        check("stats_total", stat_total, 10);
        check("stats_carry", stat_carry, 4);
        apply(1, 32'h0, 1, 1, 1);
        tick();
        check("stats_total_after_flush", stat_total, 10);
        check("stats_carry_after_flush", stat_carry, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
